// File: rtl/chip_test_ctrl_if.sv
// Operator and tester handshake bundle for the chip test controller.
// master = controller side, slave = operator panel / chip tester side.
interface chip_test_ctrl_if;
    logic       Start;
    logic       Done;
    logic       RSLT;
    logic       Run;
    logic       DISP_RSLT;
    logic       Busy;
    logic       Pass;
    logic       Fail;
    logic       Timeout;
    logic [7:0] PassCnt;
    logic [7:0] FailCnt;

    modport master (
        input  Start, Done, RSLT,
        output Run, DISP_RSLT, Busy, Pass, Fail, Timeout, PassCnt, FailCnt
    );

    modport slave (
        output Start, Done, RSLT,
        input  Run, DISP_RSLT, Busy, Pass, Fail, Timeout, PassCnt, FailCnt
    );
endinterface

// File: rtl/chip_test_ctrl.sv
// Chip test sequencer: launches one test per Start edge, qualifies Done,
// latches the verdict, acknowledges the tester and keeps saturating tallies.
module chip_test_ctrl #(
    parameter int TIMEOUT = 4096,
    parameter int ACK_MAX = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    chip_test_ctrl_if.master  bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int ACK_W  = $clog2(ACK_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CONFIRM = 3'd3,
        S_ACK     = 3'd4,
        S_SHOW    = 3'd5
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic [ACK_W-1:0]  ack_cnt_r;
    logic              start_d_r;
    logic              armed_r;
    logic              start_edge_s;
    logic              pass_r;
    logic              fail_r;
    logic              tmo_r;
    logic [7:0]        pass_cnt_r;
    logic [7:0]        fail_cnt_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = v + 8'd1;
        end
    endfunction

    // armed_r blocks a Start level that was already high when reset released
    assign start_edge_s = bus.Start & ~start_d_r & armed_r;
    assign wait_nxt_s   = wait_cnt_r + WAIT_W'(1);

    // Main sequencer: state, counters, verdict latches and tallies
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= '0;
            ack_cnt_r  <= '0;
            start_d_r  <= 1'b0;
            armed_r    <= 1'b0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
            tmo_r      <= 1'b0;
            pass_cnt_r <= 8'd0;
            fail_cnt_r <= 8'd0;
        end else begin
            start_d_r <= bus.Start;
            armed_r   <= armed_r | ~bus.Start;
            case (state_r)
                S_IDLE, S_SHOW: begin
                    if (start_edge_s) begin
                        state_r <= S_LAUNCH;
                        pass_r  <= 1'b0;
                        fail_r  <= 1'b0;
                        tmo_r   <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state_r    <= S_WAIT;
                    wait_cnt_r <= '0;
                end
                S_WAIT: begin
                    if (bus.Done) begin
                        state_r <= S_CONFIRM;
                    end else begin
                        wait_cnt_r <= wait_nxt_s;
                        if (wait_nxt_s == WAIT_LAST) begin
                            state_r    <= S_SHOW;
                            tmo_r      <= 1'b1;
                            fail_cnt_r <= sat_inc(fail_cnt_r);
                        end
                    end
                end
                S_CONFIRM: begin
                    // Done must persist two samples; a single-cycle blip resumes waiting
                    if (bus.Done) begin
                        pass_r    <= bus.RSLT;
                        fail_r    <= ~bus.RSLT;
                        ack_cnt_r <= '0;
                        state_r   <= S_ACK;
                        if (bus.RSLT) begin
                            pass_cnt_r <= sat_inc(pass_cnt_r);
                        end else begin
                            fail_cnt_r <= sat_inc(fail_cnt_r);
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_ACK: begin
                    if (!bus.Done) begin
                        state_r <= S_SHOW;
                    end else if (ack_cnt_r == ACK_LAST) begin
                        state_r <= S_SHOW;
                        tmo_r   <= 1'b1;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + ACK_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Run       = (state_r == S_LAUNCH);
    assign bus.DISP_RSLT = (state_r == S_ACK);
    assign bus.Busy      = (state_r == S_LAUNCH) || (state_r == S_WAIT) ||
                           (state_r == S_CONFIRM) || (state_r == S_ACK);
    assign bus.Pass      = pass_r;
    assign bus.Fail      = fail_r;
    assign bus.Timeout   = tmo_r;
    assign bus.PassCnt   = pass_cnt_r;
    assign bus.FailCnt   = fail_cnt_r;
endmodule

// File: tb/tb_chip_test_ctrl.sv
// Directed bench for chip_test_ctrl with hand-computed expectations
// (TIMEOUT = 16, ACK_MAX = 15).
module tb_chip_test_ctrl;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;
    int   run_cnt;
    int   r0;

    chip_test_ctrl_if bus ();

    chip_test_ctrl #(.TIMEOUT(16), .ACK_MAX(15)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (bus.Run === 1'b1) run_cnt <= run_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_run();
        int k;
        k = 0;
        while (bus.Run !== 1'b1 && k < 8) begin
            @(negedge Clk);
            k++;
        end
        check("run_seen", bus.Run, 1);
    endtask

    task automatic wait_disp();
        int k;
        k = 0;
        while (bus.DISP_RSLT !== 1'b1 && k < 8) begin
            @(negedge Clk);
            k++;
        end
        check("disp_seen", bus.DISP_RSLT, 1);
    endtask

    // Tester model: Done rises dly cycles after Run, falls ack_hold cycles after DISP_RSLT
    task automatic tester(input logic rslt, input int dly, input int ack_hold, input bit glitch);
        wait_run();
        if (glitch) begin
            step(2);
            bus.RSLT = ~rslt;
            bus.Done = 1'b1;
            step(1);
            bus.Done = 1'b0;
            bus.RSLT = rslt;
        end
        step(dly);
        check("busy_in_wait", bus.Busy, 1);
        bus.RSLT = rslt;
        bus.Done = 1'b1;
        wait_disp();
        step(ack_hold);
        bus.Done = 1'b0;
        step(2);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        run_cnt   = 0;
        Reset     = 1'b1;
        bus.Start = 1'b0;
        bus.Done  = 1'b0;
        bus.RSLT  = 1'b0;
        step(2);
        check("rst_run", bus.Run, 0);
        check("rst_disp", bus.DISP_RSLT, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_pass", bus.Pass, 0);
        check("rst_fail", bus.Fail, 0);
        check("rst_tmo", bus.Timeout, 0);
        check("rst_passcnt", bus.PassCnt, 0);
        check("rst_failcnt", bus.FailCnt, 0);
        Reset = 1'b0;
        step(2);

        // Done asserted while idle must not start anything
        bus.Done = 1'b1;
        step(4);
        check("idle_done_busy", bus.Busy, 0);
        check("idle_done_cnt", bus.PassCnt, 0);
        bus.Done = 1'b0;
        step(2);

        // Passing test
        r0 = run_cnt;
        bus.Start = 1'b1;
        tester(1'b1, 7, 1, 1'b0);
        check("pass_pass", bus.Pass, 1);
        check("pass_fail", bus.Fail, 0);
        check("pass_tmo", bus.Timeout, 0);
        check("pass_passcnt", bus.PassCnt, 1);
        check("pass_busy", bus.Busy, 0);
        check("pass_disp", bus.DISP_RSLT, 0);
        check("pass_runs", run_cnt - r0, 1);
        bus.Start = 1'b0;
        step(2);

        // Failing test
        bus.Start = 1'b1;
        tester(1'b0, 7, 1, 1'b0);
        check("fail_fail", bus.Fail, 1);
        check("fail_pass", bus.Pass, 0);
        check("fail_failcnt", bus.FailCnt, 1);
        check("fail_passcnt", bus.PassCnt, 1);
        bus.Start = 1'b0;
        step(2);

        // No response: Show 16 cycles after Launch
        bus.Start = 1'b1;
        step(1);
        check("tmo_run", bus.Run, 1);
        step(15);
        check("tmo_busy_last", bus.Busy, 1);
        check("tmo_not_yet", bus.Timeout, 0);
        step(1);
        check("tmo_busy_off", bus.Busy, 0);
        check("tmo_flag", bus.Timeout, 1);
        check("tmo_pass", bus.Pass, 0);
        check("tmo_fail", bus.Fail, 0);
        check("tmo_failcnt", bus.FailCnt, 2);
        bus.Start = 1'b0;
        step(2);

        // One-cycle Done blip with wrong verdict is rejected
        bus.Start = 1'b1;
        tester(1'b1, 3, 1, 1'b1);
        check("glitch_pass", bus.Pass, 1);
        check("glitch_fail", bus.Fail, 0);
        check("glitch_passcnt", bus.PassCnt, 2);
        check("glitch_failcnt", bus.FailCnt, 2);
        bus.Start = 1'b0;
        step(2);

        // Done never falls during Ack: released after ACK_MAX cycles, verdict kept
        bus.Start = 1'b1;
        wait_run();
        step(2);
        bus.RSLT = 1'b0;
        bus.Done = 1'b1;
        wait_disp();
        step(14);
        check("ackto_disp_held", bus.DISP_RSLT, 1);
        step(1);
        check("ackto_disp_drop", bus.DISP_RSLT, 0);
        check("ackto_tmo", bus.Timeout, 1);
        check("ackto_fail", bus.Fail, 1);
        check("ackto_failcnt", bus.FailCnt, 3);
        bus.Done = 1'b0;
        bus.Start = 1'b0;
        step(2);

        // Start held ~50 cycles with an extra edge mid-test: one launch only
        r0 = run_cnt;
        bus.Start = 1'b1;
        wait_run();
        step(2);
        bus.Start = 1'b0;
        step(1);
        bus.Start = 1'b1;
        step(3);
        bus.RSLT = 1'b1;
        bus.Done = 1'b1;
        wait_disp();
        step(1);
        bus.Done = 1'b0;
        step(40);
        check("held_runs", run_cnt - r0, 1);
        check("held_busy", bus.Busy, 0);
        check("held_passcnt", bus.PassCnt, 3);
        bus.Start = 1'b0;
        step(2);

        // 300 passing tests saturate PassCnt
        r0 = run_cnt;
        for (int i = 0; i < 300; i++) begin
            bus.Start = 1'b1;
            tester(1'b1, 2, 1, 1'b0);
            bus.Start = 1'b0;
            step(1);
        end
        step(2);
        check("sat_runs", run_cnt - r0, 300);
        check("sat_passcnt", bus.PassCnt, 255);
        check("sat_failcnt", bus.FailCnt, 3);

        // Reset while in Ack, Start held through reset release
        bus.Start = 1'b1;
        wait_run();
        step(2);
        bus.RSLT = 1'b1;
        bus.Done = 1'b1;
        wait_disp();
        #2 Reset = 1'b1;
        #1;
        check("rstack_disp", bus.DISP_RSLT, 0);
        check("rstack_busy", bus.Busy, 0);
        check("rstack_pass", bus.Pass, 0);
        check("rstack_passcnt", bus.PassCnt, 0);
        check("rstack_failcnt", bus.FailCnt, 0);
        bus.Done = 1'b0;
        step(2);
        Reset = 1'b0;
        r0 = run_cnt;
        step(10);
        check("rstheld_runs", run_cnt - r0, 0);
        check("rstheld_busy", bus.Busy, 0);
        bus.Start = 1'b0;
        step(1);
        bus.Start = 1'b1;
        step(1);
        check("rearm_run", bus.Run, 1);
        step(20);
        check("rearm_tmo", bus.Timeout, 1);
        check("rearm_runs", run_cnt - r0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/chip_test_ctrl.md
CHIP_TEST_CTRL -- requirements
Module: chip_test_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, meaning the maximum Clk cycles to wait for Done after Run.
REQ-002 SHALL have parameter ACK_MAX, default 15, meaning the maximum Clk cycles to hold DISP_RSLT waiting for Done to fall.
REQ-003 SHALL have port Clk  input  1  the single clock; all flops are rising-edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  operator request, level, synchronous to Clk.
REQ-006 SHALL have port Done  input  1  test-complete flag from the chip tester.
REQ-007 SHALL have port RSLT  input  1  tester verdict, 1 = pass.
REQ-008 SHALL have port Run  output  1  one-cycle test launch pulse to the tester.
REQ-009 SHALL have port DISP_RSLT  output  1  acknowledge to the tester, releasing it to Halted.
REQ-010 SHALL have port Busy  output  1  high while a test is in flight.
REQ-011 SHALL have port Pass  output  1  latched pass indicator.
REQ-012 SHALL have port Fail  output  1  latched fail indicator.
REQ-013 SHALL have port Timeout  output  1  latched no-response indicator.
REQ-014 SHALL have port PassCnt  output  8  saturating count of passing tests.
REQ-015 SHALL have port FailCnt  output  8  saturating count of failing or timed-out tests.

Function
REQ-016 SHALL implement states Idle, Launch, WaitDone, Confirm, Ack, Show.
REQ-017 SHALL rising-edge detect Start (registered previous value); a held Start SHALL launch at most one test.
REQ-018 Idle/Show: Start rising edge -> Launch; clear Pass, Fail and Timeout on the same edge.
REQ-019 Launch: Run = 1 for exactly one cycle; next state WaitDone; clear the wait counter.
REQ-020 WaitDone: Done = 1 -> Confirm; otherwise increment the wait counter; on reaching TIMEOUT-1 -> Show with Timeout = 1 and FailCnt incremented.
REQ-021 Confirm: Done still 1 -> sample RSLT, set Pass = RSLT and Fail = ~RSLT, increment the matching counter, go to Ack; Done = 0 -> return to WaitDone without clearing the wait counter (glitch rejection).
REQ-022 Ack: DISP_RSLT = 1; Done = 0 -> Show; after ACK_MAX cycles with Done still 1 -> Show and set Timeout (verdict kept).
REQ-023 Show: DISP_RSLT = 0, Run = 0; indicators held until the next Start edge.
REQ-024 Busy SHALL be 1 in Launch, WaitDone, Confirm and Ack, and 0 otherwise.
REQ-025 Run, DISP_RSLT and Busy SHALL be decoded from registered state only, with no combinational path from any input.
REQ-026 Exactly one of Pass/Fail SHALL be 1 after a completed test; both SHALL be 0 after a WaitDone timeout.
REQ-027 Counters SHALL hold at 255 on further increments (no wrap).
REQ-028 Start edges arriving in Launch through Ack SHALL be ignored and not queued.
REQ-029 Done = 1 already present in Idle or Show SHALL be ignored.
REQ-030 Wait counter SHALL be wide enough for TIMEOUT; the Ack counter wide enough for ACK_MAX.

Reset
REQ-031 On Reset = 1, asynchronously: state = Idle, all outputs 0, PassCnt = FailCnt = 0, counters and Start edge register = 0.
REQ-032 Reset mid-test SHALL abort immediately, with no counter update; Start held high through reset release SHALL NOT launch until it falls and rises again.

Verification
REQ-033 Start 0->1; Done rises 7 cycles after Run, RSLT = 1, Done falls 1 cycle after DISP_RSLT -> one Run pulse, Pass = 1, Fail = 0, PassCnt = 1, Busy low in Show.
REQ-034 Same sequence with RSLT = 0 -> Fail = 1, FailCnt = 1, PassCnt unchanged.
REQ-035 TIMEOUT = 16, Done never asserted -> Show after Launch + 16 cycles, Timeout = 1, Pass = Fail = 0, FailCnt = 1.
REQ-036 Done pulses high for one cycle then low, then high for 2+ cycles -> first pulse rejected, verdict sampled on the second assertion only.
REQ-037 Start held high for 50 cycles; 300 passing tests -> one launch per edge; PassCnt = 255.
REQ-038 Reset asserted while in Ack -> outputs 0 immediately, DISP_RSLT dropped, counters 0.
